// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command frame parser.
// Frame layout depends on UART_CMD_CHKSUM_EN (see uart_cmd_parser.sv).
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        DATA_H = 3'd2,
        DATA_L = 3'd3,
        CHK    = 3'd4
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CHKSUM  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    localparam logic [7:0] HEADER_DEFAULT = 8'h55;

    // 8-bit wrap-around sum of the three payload bytes.
    function automatic logic [7:0] chksum8(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [7:0] c);
        return a + b + c;
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte idle counter: clears on clr, counts while en, pulses tc at TIMEOUT-1.
module uart_cmd_timeout
#(
    parameter int TIMEOUT = 520830
)
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int             CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc = en && !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles header/cmd/data_h/data_l[/checksum] frames from a UART byte stream.
// UART_CMD_CHKSUM_EN defined: 5-byte frames with checksum; undefined: 4-byte frames.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] HEADER  = HEADER_DEFAULT,
    parameter int         TIMEOUT = 520830
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        din_vld,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_vld,
    output logic        err,
    output logic [1:0]  err_type
);

    state_e      state_q, state_d;
    logic [7:0]  cmd_sh_q, cmd_sh_d;
    logic [7:0]  dh_q, dh_d;
`ifdef UART_CMD_CHKSUM_EN
    logic [7:0]  dl_q, dl_d;
`endif
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] data_q, data_d;
    logic        cmd_vld_q, cmd_vld_d;
    logic        err_q, err_d;
    logic [1:0]  err_type_q, err_type_d;

    logic to_clr, to_en, to_tc;

    assign to_clr = din_vld || (state_q == IDLE);
    assign to_en  = (state_q != IDLE);

    uart_cmd_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (to_clr),
        .en  (to_en),
        .tc  (to_tc)
    );

    // A byte always takes priority over a coincident timeout.
    always_comb begin
        state_d    = state_q;
        cmd_sh_d   = cmd_sh_q;
        dh_d       = dh_q;
`ifdef UART_CMD_CHKSUM_EN
        dl_d       = dl_q;
`endif
        cmd_d      = cmd_q;
        data_d     = data_q;
        cmd_vld_d  = 1'b0;
        err_d      = 1'b0;
        err_type_d = err_type_q;

        if (din_vld) begin
            case (state_q)
                IDLE: begin
                    if (din == HEADER) state_d = CMD;
                end
                CMD: begin
                    cmd_sh_d = din;
                    state_d  = DATA_H;
                end
                DATA_H: begin
                    dh_d    = din;
                    state_d = DATA_L;
                end
                DATA_L: begin
`ifdef UART_CMD_CHKSUM_EN
                    dl_d    = din;
                    state_d = CHK;
`else
                    cmd_d     = cmd_sh_q;
                    data_d    = {dh_q, din};
                    cmd_vld_d = 1'b1;
                    state_d   = IDLE;
`endif
                end
`ifdef UART_CMD_CHKSUM_EN
                CHK: begin
                    if (din == chksum8(cmd_sh_q, dh_q, dl_q)) begin
                        cmd_d     = cmd_sh_q;
                        data_d    = {dh_q, dl_q};
                        cmd_vld_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_type_d = ERR_CHKSUM;
                    end
                    state_d = IDLE;
                end
`endif
                default: state_d = IDLE;
            endcase
        end else if (to_tc) begin
            state_d    = IDLE;
            err_d      = 1'b1;
            err_type_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cmd_sh_q   <= '0;
            dh_q       <= '0;
`ifdef UART_CMD_CHKSUM_EN
            dl_q       <= '0;
`endif
            cmd_q      <= '0;
            data_q     <= '0;
            cmd_vld_q  <= 1'b0;
            err_q      <= 1'b0;
            err_type_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            cmd_sh_q   <= cmd_sh_d;
            dh_q       <= dh_d;
`ifdef UART_CMD_CHKSUM_EN
            dl_q       <= dl_d;
`endif
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            cmd_vld_q  <= cmd_vld_d;
            err_q      <= err_d;
            err_type_q <= err_type_d;
        end
    end

    assign cmd      = cmd_q;
    assign data     = data_q;
    assign cmd_vld  = cmd_vld_q;
    assign err      = err_q;
    assign err_type = err_type_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with TIMEOUT=16; follows UART_CMD_CHKSUM_EN.
module tb_uart_cmd_parser;

    localparam int         TIMEOUT = 16;
    localparam logic [7:0] HDR     = 8'h55;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        din_vld;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_vld;
    logic        err;
    logic [1:0]  err_type;

    int n_cmp   = 0;
    int n_bad   = 0;
    int vld_cnt = 0;
    int err_cnt = 0;
    int v0, e0;

    logic [23:0] exp_q[$];
    logic [23:0] exp_e;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    uart_cmd_parser #(.HEADER(HDR), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_vld  (din_vld),
        .cmd      (cmd),
        .data     (data),
        .cmd_vld  (cmd_vld),
        .err      (err),
        .err_type (err_type)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            check("vld_err_excl", 32'(cmd_vld & err), 32'd0);
            if (cmd_vld) begin
                vld_cnt++;
                check("sb_vld_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_e = exp_q.pop_front();
                    check("sb_cmd_data", 32'({cmd, data}), 32'(exp_e));
                end
            end
            if (err) err_cnt++;
        end
    end

    // ---------------- drivers ----------------
    task automatic drive_byte(input logic [7:0] b);
        din     = b;
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
        din     = 8'h00;
    endtask

    // ck is the hand-computed checksum; only sent when the checksum build is active.
    task automatic send_frame(input logic [7:0] c, input logic [7:0] dh,
                              input logic [7:0] dl, input logic [7:0] ck);
        exp_q.push_back({c, dh, dl});
        drive_byte(HDR);
        drive_byte(c);
        drive_byte(dh);
        drive_byte(dl);
`ifdef UART_CMD_CHKSUM_EN
        drive_byte(ck);
`else
        if (ck == 8'h00) din = 8'h00;
`endif
        check("cmd_vld_latency", 32'(cmd_vld), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst     = 1'b1;
        din     = 8'h00;
        din_vld = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_cmd", 32'(cmd), 32'h0);
        check("rst_data", 32'(data), 32'h0);
        check("rst_cmd_vld", 32'(cmd_vld), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_err_type", 32'(err_type), 32'h0);

        // basic good frame
        send_frame(8'h01, 8'h12, 8'h34, 8'h47);
        check("t2_err", 32'(err), 32'h0);
        check("t2_cmd", 32'(cmd), 32'h01);
        check("t2_data", 32'(data), 32'h1234);
        @(negedge clk);
        check("t2_vld_single", 32'(cmd_vld), 32'h0);

        // bad checksum keeps previous outputs, then a good frame
`ifdef UART_CMD_CHKSUM_EN
        v0 = vld_cnt;
        drive_byte(8'h55); drive_byte(8'h01); drive_byte(8'h12);
        drive_byte(8'h34); drive_byte(8'h48);
        check("t3_err", 32'(err), 32'h1);
        check("t3_err_type", 32'(err_type), 32'h1);
        check("t3_cmd_vld", 32'(cmd_vld), 32'h0);
        check("t3_cmd_hold", 32'(cmd), 32'h01);
        check("t3_data_hold", 32'(data), 32'h1234);
        @(negedge clk);
        check("t3_err_single", 32'(err), 32'h0);
        check("t3_err_type_held", 32'(err_type), 32'h1);
        check("t3_no_vld", 32'(vld_cnt), 32'(v0));
`endif
        send_frame(8'h02, 8'h00, 8'h10, 8'h12);
        check("t3_good_cmd", 32'(cmd), 32'h02);
        check("t3_good_data", 32'(data), 32'h0010);

        // leading junk ignored, wrapping checksum
        e0 = err_cnt;
        drive_byte(8'hAA);
        drive_byte(8'h00);
        send_frame(8'h80, 8'hFF, 8'hFF, 8'h7E);
        check("t4_cmd", 32'(cmd), 32'h80);
        check("t4_data", 32'(data), 32'hFFFF);
        check("t4_no_err", 32'(err_cnt), 32'(e0));

        // back-to-back frames, header on the cmd_vld cycle
        v0 = vld_cnt;
        send_frame(8'h06, 8'h01, 8'h02, 8'h09);
        send_frame(8'h07, 8'h03, 8'h04, 8'h0E);
        check("t5_two_vld", 32'(vld_cnt), 32'(v0 + 2));
        check("t5_cmd", 32'(cmd), 32'h07);
        check("t5_data", 32'(data), 32'h0304);

        // inter-byte timeout
        e0 = err_cnt;
        drive_byte(8'h55);
        drive_byte(8'h01);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("t6_err_early", 32'(err), 32'h0);
        @(negedge clk);
        check("t6_err", 32'(err), 32'h1);
        check("t6_err_type", 32'(err_type), 32'h2);
        check("t6_cmd_hold", 32'(cmd), 32'h07);
        @(negedge clk);
        check("t6_err_single", 32'(err), 32'h0);
        check("t6_err_cnt", 32'(err_cnt), 32'(e0 + 1));
        send_frame(8'h04, 8'h00, 8'h01, 8'h05);
        check("t6_recover_cmd", 32'(cmd), 32'h04);
        check("t6_err_type_held", 32'(err_type), 32'h2);

        // byte arriving on the terminal-count cycle wins
        e0 = err_cnt;
        exp_q.push_back(24'h050000);
        drive_byte(8'h55);
        drive_byte(8'h05);
        repeat (TIMEOUT - 1) @(negedge clk);
        drive_byte(8'h00);
        drive_byte(8'h00);
`ifdef UART_CMD_CHKSUM_EN
        drive_byte(8'h05);
`endif
        check("t7_vld", 32'(cmd_vld), 32'h1);
        check("t7_cmd", 32'(cmd), 32'h05);
        check("t7_data", 32'(data), 32'h0000);
        check("t7_no_err", 32'(err_cnt), 32'(e0));

        // reset mid-frame aborts silently and clears outputs
        drive_byte(8'h55);
        drive_byte(8'h01);
        drive_byte(8'h12);
        rst = 1'b1;
        @(negedge clk);
        check("t8_cmd", 32'(cmd), 32'h0);
        check("t8_data", 32'(data), 32'h0);
        check("t8_err_type", 32'(err_type), 32'h0);
        check("t8_err", 32'(err), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        v0 = vld_cnt;
        e0 = err_cnt;
        drive_byte(8'h34);
        drive_byte(8'h47);
        repeat (TIMEOUT + 4) @(negedge clk);
        check("t8_no_vld", 32'(vld_cnt), 32'(v0));
        check("t8_no_err", 32'(err_cnt), 32'(e0));
        check("t8_cmd_after", 32'(cmd), 32'h0);
        check("t8_data_after", 32'(data), 32'h0);

        // frame after reset
        send_frame(8'h03, 8'hAB, 8'hCD, 8'h7B);
        check("t9_cmd", 32'(cmd), 32'h03);
        check("t9_data", 32'(data), 32'hABCD);
        @(negedge clk);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
